// File: rtl/mem_arbiter.sv
// Two-requester (cpu/gpu) round-robin memory arbiter.
// One outstanding transaction, registered outputs, wait timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_cpu_req,
  input  logic                  in_cpu_we,
  input  logic [ADDR_WIDTH-1:0] in_cpu_addr,
  input  logic [DATA_WIDTH-1:0] in_cpu_wdata,
  output logic                  out_cpu_ack,
  output logic                  out_cpu_err,
  output logic [DATA_WIDTH-1:0] out_cpu_rdata,
  input  logic                  in_gpu_req,
  input  logic                  in_gpu_we,
  input  logic [ADDR_WIDTH-1:0] in_gpu_addr,
  input  logic [DATA_WIDTH-1:0] in_gpu_wdata,
  output logic                  out_gpu_ack,
  output logic                  out_gpu_err,
  output logic [DATA_WIDTH-1:0] out_gpu_rdata,
  output logic [ADDR_WIDTH-1:0] out_mem_read_addr,
  output logic                  out_mem_read_ready,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic                  in_mem_data_ready,
  output logic [ADDR_WIDTH-1:0] out_mem_write_addr,
  output logic [DATA_WIDTH-1:0] out_mem_write_data,
  output logic                  out_mem_write_ready,
  input  logic                  in_mem_write_ready
);

  // Counter holds 0..TIMEOUT_CYCLES-1; the last value expires.
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_M1 =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LIM = CW'(TO_M1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  gnt;
  logic                  last_gpu;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt;

  logic                  any_req;
  logic                  pick_gpu;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  done;
  logic                  expire;

  // Round-robin pick and mux of the winner's request fields.
  always_comb begin
    any_req   = in_cpu_req | in_gpu_req;
    pick_gpu  = in_gpu_req & (~in_cpu_req | ~last_gpu);
    sel_we    = pick_gpu ? in_gpu_we    : in_cpu_we;
    sel_addr  = pick_gpu ? in_gpu_addr  : in_cpu_addr;
    sel_wdata = pick_gpu ? in_gpu_wdata : in_cpu_wdata;
    done      = we_q ? in_mem_write_ready
                     : in_mem_data_ready;
    expire    = TO_EN && (cnt == TO_LIM);
  end

  // Next-state logic; completion takes priority over expiry.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = WAIT;
      WAIT: if (done || expire) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant, latch, memory strobes and requester responses.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      gnt                 <= 1'b0;
      last_gpu            <= 1'b1;
      we_q                <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      cnt                 <= '0;
      out_cpu_ack         <= 1'b0;
      out_cpu_err         <= 1'b0;
      out_cpu_rdata       <= '0;
      out_gpu_ack         <= 1'b0;
      out_gpu_err         <= 1'b0;
      out_gpu_rdata       <= '0;
      out_mem_read_addr   <= '0;
      out_mem_read_ready  <= 1'b0;
      out_mem_write_addr  <= '0;
      out_mem_write_data  <= '0;
      out_mem_write_ready <= 1'b0;
    end else begin
      out_mem_read_ready  <= 1'b0;
      out_mem_write_ready <= 1'b0;
      out_cpu_ack         <= 1'b0;
      out_cpu_err         <= 1'b0;
      out_gpu_ack         <= 1'b0;
      out_gpu_err         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= pick_gpu;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt     <= '0;
            if (sel_we) begin
              out_mem_write_addr  <= sel_addr;
              out_mem_write_data  <= sel_wdata;
              out_mem_write_ready <= 1'b1;
            end else begin
              out_mem_read_addr  <= sel_addr;
              out_mem_read_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (done || expire) begin
            if (gnt) begin
              out_gpu_ack   <= 1'b1;
              out_gpu_err   <= ~done;
              out_gpu_rdata <= (done && !we_q)
                               ? in_mem_data : '0;
            end else begin
              out_cpu_ack   <= 1'b1;
              out_cpu_err   <= ~done;
              out_cpu_rdata <= (done && !we_q)
                               ? in_mem_data : '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last_gpu <= gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT_CYCLES = 4.
// Table of single transactions plus tie and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        gpu_req = 0, gpu_we = 0;
  logic [15:0] gpu_addr = '0;
  logic [31:0] gpu_wdata = '0;
  logic        cpu_ack, cpu_err, gpu_ack, gpu_err;
  logic [31:0] cpu_rdata, gpu_rdata;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        rd_stb, wr_stb;
  logic [31:0] mem_data = '0;
  logic        mem_data_ready = 0;
  logic        mem_write_ready = 0;
  logic        auto_mem = 0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .in_cpu_req(cpu_req),
    .in_cpu_we(cpu_we),
    .in_cpu_addr(cpu_addr),
    .in_cpu_wdata(cpu_wdata),
    .out_cpu_ack(cpu_ack),
    .out_cpu_err(cpu_err),
    .out_cpu_rdata(cpu_rdata),
    .in_gpu_req(gpu_req),
    .in_gpu_we(gpu_we),
    .in_gpu_addr(gpu_addr),
    .in_gpu_wdata(gpu_wdata),
    .out_gpu_ack(gpu_ack),
    .out_gpu_err(gpu_err),
    .out_gpu_rdata(gpu_rdata),
    .out_mem_read_addr(rd_addr),
    .out_mem_read_ready(rd_stb),
    .in_mem_data(mem_data),
    .in_mem_data_ready(mem_data_ready),
    .out_mem_write_addr(wr_addr),
    .out_mem_write_data(wr_data),
    .out_mem_write_ready(wr_stb),
    .in_mem_write_ready(mem_write_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gpu;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          dly;
    logic        noresp;
    logic        spur;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_excl", {63'd0, cpu_ack & gpu_ack}, 0);
    chk("stb_excl", {63'd0, rd_stb & wr_stb}, 0);
    if (auto_mem) begin
      mem_data_ready  = rd_stb;
      mem_write_ready = wr_stb;
      mem_data        = {16'hA5A5, rd_addr};
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   c;
    logic got;
    logic rdy;
    logic own_ack, oth_ack, own_err;
    logic [31:0] own_rd;
    if (v.gpu) begin
      gpu_req = 1; gpu_we = v.we;
      gpu_addr = v.addr; gpu_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we;
      cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    mem_data = 32'hBAD0BAD0;
    tick();
    if (v.we) begin
      chk("wr_stb", {63'd0, wr_stb}, 1);
      chk("wr_addr", {48'd0, wr_addr}, {48'd0, v.addr});
      chk("wr_data", {32'd0, wr_data}, {32'd0, v.wdata});
      chk("rd_stb_idle", {63'd0, rd_stb}, 0);
    end else begin
      chk("rd_stb", {63'd0, rd_stb}, 1);
      chk("rd_addr", {48'd0, rd_addr}, {48'd0, v.addr});
      chk("wr_stb_idle", {63'd0, wr_stb}, 0);
    end
    c = 0;
    got = 0;
    while (!got && c < 12) begin
      rdy = !v.noresp && (c == v.dly);
      if (v.we) begin
        mem_write_ready = rdy;
        mem_data_ready  = v.spur;
      end else begin
        mem_data_ready  = rdy;
        mem_write_ready = v.spur;
      end
      mem_data = rdy ? v.mdata : 32'hBAD0BAD0;
      tick();
      c++;
      chk("stb_once", {63'd0, rd_stb | wr_stb}, 0);
      own_ack = v.gpu ? gpu_ack : cpu_ack;
      oth_ack = v.gpu ? cpu_ack : gpu_ack;
      chk("other_ack", {63'd0, oth_ack}, 0);
      if (own_ack) got = 1;
    end
    mem_data_ready = 0;
    mem_write_ready = 0;
    cpu_req = 0;
    gpu_req = 0;
    chk("ack_seen", {63'd0, got}, 1);
    if (got) begin
      own_err = v.gpu ? gpu_err : cpu_err;
      own_rd  = v.gpu ? gpu_rdata : cpu_rdata;
      chk("err", {63'd0, own_err}, {63'd0, v.err});
      chk("rdata", {32'd0, own_rd}, {32'd0, v.rdata});
      chk("latency", 64'(c), 64'(v.lat));
      chk("addr_hold",
          {48'd0, v.we ? wr_addr : rd_addr},
          {48'd0, v.addr});
    end
    tick();
    chk("ack_drop", {63'd0, cpu_ack | gpu_ack}, 0);
    chk("err_drop", {63'd0, cpu_err | gpu_err}, 0);
  endtask

  task automatic run_tie(input int n);
    int   k;
    int   cyc;
    logic first;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0001; cpu_wdata = 32'h12345678;
    gpu_req = 1; gpu_we = 0;
    gpu_addr = 16'h0002; gpu_wdata = 32'h0;
    auto_mem = 1;
    k = 0;
    cyc = 0;
    first = 0;
    while (k < n && cyc < 60) begin
      tick();
      cyc++;
      if (!first && (rd_stb || wr_stb)) begin
        first = 1;
        chk("tie_first_wr", {63'd0, wr_stb}, 1);
        chk("tie_wr_addr", {48'd0, wr_addr}, 64'h1);
        chk("tie_wr_data", {32'd0, wr_data},
            64'h12345678);
      end
      if (cpu_ack || gpu_ack) begin
        chk("tie_order", {63'd0, gpu_ack}, 64'(k % 2));
        if (gpu_ack) begin
          chk("tie_gpu_rd", {32'd0, gpu_rdata},
              64'hA5A50002);
          chk("tie_gpu_err", {63'd0, gpu_err}, 0);
        end else begin
          chk("tie_cpu_rd", {32'd0, cpu_rdata}, 0);
          chk("tie_cpu_err", {63'd0, cpu_err}, 0);
        end
        k++;
        if (k == n) begin
          cpu_req = 0;
          gpu_req = 0;
        end
      end
    end
    chk("tie_count", 64'(k), 64'(n));
    auto_mem = 0;
    cpu_req = 0;
    gpu_req = 0;
    mem_data_ready = 0;
    mem_write_ready = 0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 0, 16'h0010, 32'h0, 32'hDEADBEEF,
                1, 0, 0, 0, 32'hDEADBEEF, 2};
    vecs[1] = '{1, 1, 16'h0ABC, 32'hCAFEF00D, 32'h0,
                0, 0, 0, 0, 32'h0, 1};
    vecs[2] = '{1, 0, 16'h0020, 32'h0, 32'h0,
                0, 1, 0, 1, 32'h0, 4};
    vecs[3] = '{1, 0, 16'h0021, 32'h0, 32'h01234567,
                2, 0, 0, 0, 32'h01234567, 3};
    vecs[4] = '{0, 0, 16'h0030, 32'h0, 32'h55AA55AA,
                3, 0, 1, 0, 32'h55AA55AA, 4};
    vecs[5] = '{0, 1, 16'h0031, 32'h0F0F0F0F, 32'h0,
                3, 0, 1, 0, 32'h0, 4};
    vecs[6] = '{0, 0, 16'h0032, 32'h0, 32'h0,
                0, 1, 1, 1, 32'h0, 4};
    vecs[7] = '{1, 1, 16'h0040, 32'h89ABCDEF, 32'h0,
                0, 1, 0, 1, 32'h0, 4};
    vecs[8] = '{0, 0, 16'hFFFF, 32'h0, 32'hFFFFFFFF,
                0, 0, 0, 0, 32'hFFFFFFFF, 1};

    rst = 1;
    tick();
    tick();
    chk("rst_cpu_ack", {63'd0, cpu_ack}, 0);
    chk("rst_gpu_ack", {63'd0, gpu_ack}, 0);
    chk("rst_cpu_rd", {32'd0, cpu_rdata}, 0);
    chk("rst_gpu_rd", {32'd0, gpu_rdata}, 0);
    chk("rst_strobes", {62'd0, rd_stb, wr_stb}, 0);
    chk("rst_addrs", {32'd0, rd_addr, wr_addr}, 0);
    chk("rst_wdata", {32'd0, wr_data}, 0);
    rst = 0;

    run_tie(4);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0060;
    tick();
    chk("ar_stb", {63'd0, rd_stb}, 1);
    #3 rst = 1;
    cpu_req = 0;
    #1;
    chk("ar_stb_async", {63'd0, rd_stb}, 0);
    chk("ar_addr_async", {48'd0, rd_addr}, 0);
    @(posedge clk);
    #2 rst = 0;
    #1;
    mem_data_ready = 1;
    mem_data = 32'h77777777;
    tick();
    mem_data_ready = 0;
    chk("ar_late_ack", {63'd0, cpu_ack | gpu_ack}, 0);
    tick();
    chk("ar_late_ack2", {63'd0, cpu_ack | gpu_ack}, 0);
    chk("ar_late_rd", {32'd0, cpu_rdata}, 0);

    run_tie(2);

    run_vec('{0, 0, 16'h0050, 32'h0, 32'hA1B2C3D4,
              1, 0, 0, 0, 32'hA1B2C3D4, 2});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 16, memory address width; DATA_WIDTH, default 32, memory word width; TIMEOUT_CYCLES, default 255, maximum wait for a memory response, 0 = timeout disabled.
REQ-002 SHALL have the following ports, listed as name, direction, width, meaning:
- in_clk  input  1  single clock; all logic on the rising edge.
- in_rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide per requester port group X in {cpu, gpu}:
- in_X_req  input  1  request; held high until out_X_ack.
- in_X_we  input  1  1 = write, 0 = read.
- in_X_addr  input  ADDR_WIDTH  word address.
- in_X_wdata  input  DATA_WIDTH  write data.
- out_X_ack  output  1  one-cycle completion pulse.
- out_X_err  output  1  valid with ack; 1 = timeout.
- out_X_rdata  output  DATA_WIDTH  read data, valid with ack.
REQ-004 SHALL provide the memory-side ports:
- out_mem_read_addr  output  ADDR_WIDTH
- out_mem_read_ready  output  1  one-cycle read strobe.
- in_mem_data  input  DATA_WIDTH
- in_mem_data_ready  input  1  read data valid.
- out_mem_write_addr  output  ADDR_WIDTH
- out_mem_write_data  output  DATA_WIDTH
- out_mem_write_ready  output  1  one-cycle write strobe.
- in_mem_write_ready  input  1  write complete.
REQ-005 SHALL register all outputs; no combinational input-to-output path.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, RESP, with at most one memory transaction outstanding.
REQ-007 IDLE: at an edge where any req is high, SHALL select a grantee and latch its we/addr/wdata. It SHALL drive that address/data on the matching mem outputs, assert the matching strobe for exactly one cycle, and go to WAIT. With no req, it SHALL remain in IDLE.
REQ-008 Arbitration SHALL be round-robin:
- Only one requester active: grant it.
- Both active: grant the one not granted last.
- last_grant resets to gpu, so cpu wins the first tie.
REQ-009 WAIT, read: at an edge with in_mem_data_ready high, SHALL register out_X_rdata = in_mem_data, out_X_ack = 1, out_X_err = 0 for the grantee only, and go to RESP.
REQ-010 WAIT, write: at an edge with in_mem_write_ready high, SHALL register out_X_ack = 1, out_X_err = 0, out_X_rdata = 0, and go to RESP.
REQ-011 Timeout: a wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- If it reaches TIMEOUT_CYCLES (non-zero) without the completion input, ack with err = 1, rdata = 0, and go to RESP.
- If completion and timeout coincide, completion wins with err = 0.
REQ-012 RESP: SHALL deassert ack/err, ignore all req inputs, update last_grant to the completed grantee, and go to IDLE. This gives the requester one cycle to drop or replace req.
REQ-013 The latched address/data and the non-selected mem outputs SHALL hold their values outside the strobe cycle. Mem strobes SHALL never both be high.
REQ-014 Memory ready inputs SHALL be ignored in IDLE and RESP. A ready for the other transaction type during WAIT SHALL be ignored.
REQ-015 Minimum latency, req sampled to ack high, SHALL be 2 cycles when memory answers in the cycle after the strobe. Minimum request-to-request throughput SHALL be 1 transaction per 4 cycles.
REQ-016 out_cpu_ack and out_gpu_ack SHALL never be high together. Requester req changes during WAIT SHALL not affect the ongoing transaction.

Reset
REQ-017 in_rst high SHALL immediately, without waiting for a clock edge, force:
- State IDLE, last_grant = gpu, counter = 0.
- All ack, err, rdata, strobe, address, and data outputs = 0.
REQ-018 Reset mid-transaction SHALL abandon it with no ack issued. A late memory response after reset release SHALL be ignored per REQ-014.
REQ-019 After in_rst falls, the first req SHALL be sampled at the first rising edge.

Verification
REQ-020 Single read: cpu req, we = 0, addr = 0x0010; memory returns 0xDEADBEEF one cycle after the strobe -> out_mem_read_ready pulses once with addr 0x0010, then out_cpu_ack = 1 with rdata 0xDEADBEEF, err = 0. Latency = 2 cycles.
REQ-021 Contention: cpu and gpu both hold req (cpu write 0x0001 <= 0x12345678, gpu read 0x0002) -> cpu served first, then gpu. A second tie after both complete grants cpu again only after gpu; grant order cpu, gpu, cpu, gpu over 4 tied transactions.
REQ-022 Timeout: gpu read, memory never responds, TIMEOUT_CYCLES = 4 -> out_gpu_ack = 1 with err = 1, rdata = 0 after 4 WAIT cycles. Next transaction proceeds normally.
REQ-023 Coincident completion and timeout on the same edge -> ack with err = 0. A spurious in_mem_write_ready during a read WAIT is ignored.
REQ-024 Asynchronous reset asserted mid-WAIT between clock edges -> outputs 0 immediately. A subsequent in_mem_data_ready pulse produces no ack. A new cpu req after release completes normally.
